md5_msg_padder: RTL
===================

// Module: md5_msg_padder
// PURPOSE
//  Streaming MD5 pre-processor: accepts arbitrary-length messages as DATA_W-bit words, appends
//  0x80, zero fill and the 64-bit little-endian bit length, and emits 512-bit blocks.
//  Successor to the fixed 128-bit single-block front end of pancham: multi-block messages,
//  parametrised input width, valid/ready backpressure on both sides. Feeds the MD5 round engine.
// PARAMETERS
//  DATA_W   32   input word width; legal values 8, 32, 64. BPW = DATA_W/8 bytes per word.
// PORTS
//  clk         in   1          single clock, rising edge
//  reset       in   1          synchronous, active-high
//  in_data     in   DATA_W     message bytes; first byte in message order at [DATA_W-1 -: 8]
//  in_bytes    in   clog2(BPW)+1  valid bytes in word, 0..BPW; sampled only when in_last=1
//  in_last     in   1          final word of message
//  in_valid    in   1          word present
//  in_ready    out  1          word accepted when in_valid & in_ready
//  out_block   out  512        block; byte k at [511-8k -: 8]
//  out_first   out  1          first block of message
//  out_last    out  1          final (length-bearing) block of message
//  out_valid   out  1          block present
//  out_ready   in   1          block taken when out_valid & out_ready
// BEHAVIOUR
//  Reset (sync, 1 cycle min): state=S_FILL, byte ptr=0, len=0, first flag=1; out_valid=0,
//   out_first=0, out_last=0, out_block=0; in_ready=0 while reset high. Reset mid-message
//   discards all buffered data and any pending block.
//  FSM: S_FILL, S_PAD, S_XTRA, S_OUT.
//   S_FILL: in_ready=1. Non-last word: BPW bytes written at ptr, ptr+=BPW, len+=8*BPW.
//     ptr wraps to 64 -> S_OUT (out_valid next cycle, out_last=0).
//     Last word: write in_bytes bytes, ptr+=in_bytes, len+=8*in_bytes -> S_PAD.
//   S_PAD (1 cycle, in_ready=0): byte[ptr]=0x80 unless ptr==64; bytes ptr+1..63 zeroed.
//     ptr<=55 -> bytes 56..63 = len LE (byte56=len[7:0]), out_last=1 -> S_OUT.
//     56<=ptr<=63 -> out_last=0 -> S_OUT, then S_XTRA with 0x80 already placed.
//     ptr==64 -> out_last=0 -> S_OUT, then S_XTRA with 0x80 still owed.
//   S_XTRA: block = zeros, byte0=0x80 iff owed, bytes 56..63=len LE; out_last=1 -> S_OUT.
//   S_OUT: out_valid=1; out_block/out_first/out_last held stable until out_ready.
//     On handshake: first flag cleared; out_last=1 -> S_FILL, ptr=0, len=0, first flag=1;
//     pending extra block -> S_XTRA; else -> S_FILL, ptr=0.
//  Latency: full non-last word accepted at T -> out_valid at T+1. in_last accepted at T ->
//   out_valid at T+2. Extra block -> out_valid 2 cycles after previous handshake.
//  No overlap: in_ready=0 whenever not in S_FILL; one buffered block, no skid.
//  Non-last words must carry BPW bytes; in_bytes ignored. in_bytes>BPW on last word
//   saturates to BPW. in_last with in_bytes=0 is legal (empty tail, incl. empty message).
//  len is 64-bit, wraps mod 2^64 per MD5. Unused in_data bytes ignored (never leak to block).
//  out_first asserted only on the first block of each message; both first and last on
//   single-block messages.
// STRUCTURE
//  md5_pkg: MD5_BLOCK_BITS=512, MD5_BLOCK_BYTES=64, MD5_LEN_OFS=56, MD5_PAD_BYTE=8'h80,
//   state enum pad_state_t, helper function for byte-lane write enable.
//  One sub-module: md5_len_le -- places 64-bit length into bytes 56..63 little-endian (comb).
//  Datapath: 64x8 byte buffer with per-byte write enables indexed by ptr.
// TESTING (DATA_W=32 unless stated)
//  1 "abc": 32'h61626300, in_bytes=3, last -> one block [511:480]=32'h61626380, byte56=0x18,
//    all else 0; out_first=out_last=1; out_valid 2 cycles after accept.
//  2 Empty message: in_bytes=0, last -> byte0=0x80, all other bytes 0, first=last=1.
//  3 56 x 'a' (14 words, last in_bytes=4) -> blk0 bytes0..55=0x61, byte56=0x80, rest 0,
//    first=1 last=0; blk1 zeros except byte56=0xC0, byte57=0x01, first=0 last=1.
//  4 64 x 'a' -> blk0 all 0x61 (valid cycle after 16th word); blk1 byte0=0x80, byte57=0x02.
//  5 Backpressure: out_ready low 20 cycles on test 3 -> out_valid, out_block stable,
//    in_ready=0 throughout; both blocks correct after release. Repeat with DATA_W=8, 64.
//  6 Reset after 7 words of a message -> subsequent "abc" yields exactly test 1 block.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 message padder.
//   MD5_BLOCK_BITS / MD5_BLOCK_BYTES : size of one MD5 block
//   MD5_LEN_OFS                      : byte offset of the 64-bit length field
//   MD5_PAD_BYTE                     : first padding byte that follows the message
//   pad_state_t                      : padder FSM states
//   lane_we()                        : input byte-lane write enable
package md5_pkg;

    localparam int         MD5_BLOCK_BITS  = 512;
    localparam int         MD5_BLOCK_BYTES = 64;
    localparam int         MD5_LEN_OFS     = 56;
    localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        S_FILL,   // accepting message words
        S_PAD,    // closing the block that holds the message tail
        S_XTRA,   // building a block with only padding and length
        S_OUT     // presenting a block downstream
    } pad_state_t;

    // An input lane is written only if it carries one of the word's valid bytes.
    function automatic logic lane_we(input int unsigned lane, input logic [6:0] nbytes);
        return lane < 32'(nbytes);
    endfunction

endpackage

// File: rtl/md5_len_le.sv
// Places the 64-bit message bit length into the last eight block bytes,
// least significant byte first.
//   len       : message length in bits
//   len_field : bytes 56..63 of the block, byte 56 at [63:56]
module md5_len_le
    import md5_pkg::*;
(
    input  logic [63:0] len,
    output logic [63:0] len_field
);

    localparam int LEN_BYTES = MD5_BLOCK_BYTES - MD5_LEN_OFS;

    always_comb begin
        // NOTE: every combinational output gets a default before any conditional
        // or looped assignment, so no path can leave it unassigned and infer a latch.
        len_field = '0;
        for (int j = 0; j < LEN_BYTES; j++) begin
            len_field[63 - 8*j -: 8] = len[8*j +: 8];
        end
    end

endmodule

// File: rtl/md5_msg_padder.sv
// Streaming MD5 pre-processor: gathers message words into a 64-byte buffer,
// appends 0x80, zero fill and the 64-bit little-endian bit length, and hands
// out complete 512-bit blocks with valid/ready flow control.
//   clk, reset           : clock, synchronous active-high reset
//   in_data/in_bytes     : message word (first byte at the top) and tail byte count
//   in_last/in_valid     : final word of message / word present
//   in_ready             : word accepted on in_valid & in_ready
//   out_block            : block, byte k at [511-8k -: 8]
//   out_first/out_last   : first / length-bearing block of the message
//   out_valid/out_ready  : block handshake
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BPW    = DATA_W / 8,
    localparam int IBW    = $clog2(BPW) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [IBW-1:0]            in_bytes,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [MD5_BLOCK_BITS-1:0] out_block,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [6:0] PTR_FULL     = 7'(MD5_BLOCK_BYTES);
    localparam logic [6:0] PTR_LEN_FITS = 7'(MD5_LEN_OFS - 1);

    pad_state_t  state;
    logic [6:0]  ptr;          // next free byte, 64 when the buffer is full
    logic [63:0] len;          // message length in bits, wraps mod 2^64
    logic        first_flag;   // next block presented is the message's first
    logic        owed;         // extra block must start with 0x80
    logic        xtra_pend;    // an extra length block follows the current one

    logic [7:0]  blk_buf [MD5_BLOCK_BYTES];
    logic        fill_we [MD5_BLOCK_BYTES];
    logic [7:0]  fill_d  [MD5_BLOCK_BYTES];
    logic [6:0]  n_eff;
    logic        in_fire;
    logic [63:0] len_field;

    md5_len_le u_len_le (
        .len       (len),
        .len_field (len_field)
    );

    assign in_ready = (state == S_FILL) && !reset;
    assign in_fire  = in_valid && in_ready;

    // Bytes taken from this word: always a full word unless it is the last,
    // where the count saturates at BPW.
    always_comb begin
        n_eff = 7'(BPW);
        if (in_last) begin
            n_eff = (int'(in_bytes) > BPW) ? 7'(BPW) : 7'(in_bytes);
        end
    end

    // Steer the word's valid lanes onto buffer bytes ptr..ptr+n_eff-1.
    always_comb begin
        for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
            fill_we[k] = 1'b0;
            fill_d[k]  = 8'h00;
        end
        for (int j = 0; j < BPW; j++) begin
            if (lane_we(j, n_eff)) begin
                fill_we[ptr[5:0] + 6'(j)] = 1'b1;
                fill_d[ptr[5:0] + 6'(j)]  = in_data[DATA_W-1-8*j -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the buffer is plain flops rather than a RAM, so it is reset;
            // that is what makes out_block read zero after reset.
            for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
                blk_buf[i] <= 8'h00;
            end
        end else begin
            case (state)
                S_FILL: begin
                    if (in_fire) begin
                        for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
                            if (fill_we[i]) blk_buf[i] <= fill_d[i];
                        end
                    end
                end
                S_PAD: begin
                    // With ptr==64 neither compare hits and the full block is kept.
                    for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
                        if (7'(i) == ptr)     blk_buf[i] <= MD5_PAD_BYTE;
                        else if (7'(i) > ptr) blk_buf[i] <= 8'h00;
                    end
                    if (ptr <= PTR_LEN_FITS) begin
                        for (int j = 0; j < 8; j++) begin
                            blk_buf[MD5_LEN_OFS + j] <= len_field[63 - 8*j -: 8];
                        end
                    end
                end
                S_XTRA: begin
                    for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
                        blk_buf[i] <= 8'h00;
                    end
                    blk_buf[0] <= owed ? MD5_PAD_BYTE : 8'h00;
                    for (int j = 0; j < 8; j++) begin
                        blk_buf[MD5_LEN_OFS + j] <= len_field[63 - 8*j -: 8];
                    end
                end
                default: ;  // S_OUT holds the block
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every register here updates
        // from pre-edge values regardless of statement order.
        if (reset) begin
            state      <= S_FILL;
            ptr        <= '0;
            len        <= '0;
            first_flag <= 1'b1;
            owed       <= 1'b0;
            xtra_pend  <= 1'b0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_fire) begin
                        ptr <= ptr + n_eff;
                        len <= len + {54'd0, n_eff, 3'd0};
                        if (in_last) begin
                            state <= S_PAD;
                        end else if (ptr + n_eff == PTR_FULL) begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            out_first <= first_flag;
                            out_last  <= 1'b0;
                            xtra_pend <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    state     <= S_OUT;
                    out_valid <= 1'b1;
                    out_first <= first_flag;
                    if (ptr <= PTR_LEN_FITS) begin
                        out_last  <= 1'b1;
                        xtra_pend <= 1'b0;
                    end else begin
                        // No room for the length; 0x80 is owed when ptr hit 64.
                        out_last  <= 1'b0;
                        xtra_pend <= 1'b1;
                        owed      <= (ptr == PTR_FULL);
                    end
                end
                S_XTRA: begin
                    state     <= S_OUT;
                    out_valid <= 1'b1;
                    out_first <= first_flag;
                    out_last  <= 1'b1;
                    xtra_pend <= 1'b0;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        first_flag <= 1'b0;
                        if (out_last) begin
                            state      <= S_FILL;
                            ptr        <= '0;
                            len        <= '0;
                            first_flag <= 1'b1;
                        end else if (xtra_pend) begin
                            state <= S_XTRA;
                        end else begin
                            state <= S_FILL;
                            ptr   <= '0;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    always_comb begin
        out_block = '0;
        for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
            out_block[MD5_BLOCK_BITS-1-8*k -: 8] = blk_buf[k];
        end
    end

endmodule
